imm_share_arb: RTL and testbench
================================

# imm_share_arb

Arbitrated front end for the single shared immediate generator in the decode path. Two requesters (port 0: decode stage, port 1: fetch-side branch predecoder) present 32-bit RV32I instruction words. The block grants one per cycle round-robin, drives the winner through one internal `ImmGen` instance, and returns the sign-extended immediate through a one-entry registered response slot with valid/ready backpressure. It tags each response with the originating port.

## Interface
- `XLEN`, 32: instruction and immediate width; only 32 is supported.
- `i_clk` input 1: clock; all state updates on the rising edge.
- `i_rst` input 1: reset, asynchronous, active-high.
- `i_flush` input 1: synchronous flush; drops the response slot and blocks grants this cycle.
- `i_req0_valid` input 1: port 0 has an instruction.
- `i_req0_instr` input 32: port 0 instruction word.
- `o_req0_ready` output 1: port 0 granted; the word is accepted at this edge.
- `i_req1_valid` input 1: port 1 has an instruction.
- `i_req1_instr` input 32: port 1 instruction word.
- `o_req1_ready` output 1: port 1 granted; the word is accepted at this edge.
- `o_rsp_valid` output 1: response slot holds a result.
- `o_rsp_imm` output 32: registered immediate, per `ImmGen` decoding (I/S/B/U/J, sign-extended).
- `o_rsp_id` output 1: port that produced `o_rsp_imm`.
- `i_rsp_ready` input 1: consumer takes the response at this edge.

## Operation
- State: response slot (`valid`, `imm[31:0]`, `id`) and the round-robin pointer `rr_ptr`. `rr_ptr` names the port preferred on a tie.
- Slot free condition: `free = !o_rsp_valid || i_rsp_ready`.
- Grant is combinational, computed when `free && !i_flush`:
  - only port k valid: grant k;
  - both valid: grant `rr_ptr`;
  - neither valid: no grant.
- `o_reqk_ready` = grant to k. At most one ready is high per cycle. Ready is never high without the matching valid.
- A word is accepted when its port's valid and ready are both high.
- On accept of port k:
  - the muxed instruction feeds `ImmGen`;
  - its output loads into `imm`, and `id` <= k, `valid` <= 1;
  - `rr_ptr` <= ~k.
- No accept and `i_rsp_ready && o_rsp_valid`: `valid` <= 0.
- No accept and no drain: slot holds. `o_rsp_imm` and `o_rsp_id` stay stable while `o_rsp_valid && !i_rsp_ready`.
- Requesters must hold valid and instruction stable until accepted. Requester valid must not depend on ready.
- `i_flush` high:
  - `valid` <= 0 at the edge;
  - both readies low;
  - `rr_ptr` unchanged;
  - flush has priority over drain and accept.
- Undefined opcodes yield whatever `ImmGen` produces; the block does not check them.
- `imm` and `id` are only required to be correct while `valid` is 1.

## Timing
- Reset values:
  - `o_rsp_valid` = 0, `o_rsp_imm` = 0, `o_rsp_id` = 0, `rr_ptr` = 0;
  - `o_req0_ready` and `o_req1_ready` = 0 while `i_rst` is high.
- Latency: accept at edge N, response valid from edge N through at least one cycle.
- Throughput: one accept per cycle with the consumer continuously ready. Accept and drain in the same cycle sustain full rate with no bubble.
- Slot full and consumer not ready: both readies low (backpressure). Acceptance resumes in the cycle `i_rsp_ready` is high.
- Both ports continuously valid with a continuously ready consumer: grants strictly alternate 0,1,0,1 from reset.
- Reset asserted mid-operation clears the slot and `rr_ptr` immediately (asynchronously). A pending accepted result is lost.
- Only one stage in the path: mux → `ImmGen` → register. No combinational path from `i_reqk_instr` to `o_rsp_imm`.
- The combinational paths are:
  - `i_rsp_ready` to `o_reqk_ready`;
  - `i_reqk_valid` to the other port's ready;
  - `i_flush` to both readies.

## Test plan
- Reset, single port 0:
  - 0xFFF00093 (addi -1): ready0 high the same cycle;
  - next cycle `o_rsp_valid`=1, `o_rsp_imm`=0xFFFFFFFF, `o_rsp_id`=0.
- Formats via port 1, consumer always ready, back-to-back issue; the response stream must be one per cycle with `id`=1:
  - 0x123450B7 → 0x12345000;
  - 0x00112423 → 0x00000008;
  - 0xFE000EE3 → 0xFFFFFFFC;
  - 0x0000006F → 0x00000000.
- Both ports valid for 6 cycles after reset, consumer ready:
  - grant order 0,1,0,1,0,1;
  - response ids match that order.
- Backpressure:
  - fill the slot from port 0 with 0xFFF00093, then hold `i_rsp_ready`=0 for 3 cycles with port 1 valid;
  - `o_rsp_imm` stays 0xFFFFFFFF and ready1 stays 0;
  - raise `i_rsp_ready`: ready1 high that cycle, and the next response comes from port 1.
- Flush with slot full and `i_rsp_ready`=0, port 0 valid:
  - next cycle `o_rsp_valid`=0 and no grant in the flush cycle;
  - `rr_ptr` is unchanged, so a subsequent tie grants the same port as it would have without the flush.
- Asynchronous reset asserted mid-cycle while the slot holds a result:
  - `o_rsp_valid` drops before the next clock edge;
  - after release, the first tie grants port 0.

Source files
------------

// File: rtl/imm_share_arb.sv
// rtl/imm_share_arb.sv - round-robin two-port front end for the shared RV32I immediate generator
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] imm_o
);
    logic [6:0] opcode;
    assign opcode = instr_i[6:0];

    always_comb begin
        imm_o = '0;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011:
                imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            7'b0100011:
                imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            7'b1100011:
                imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm_o = {instr_i[31:12], 12'b0};
            7'b1101111:
                imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end
endmodule

module imm_share_arb #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_req0_valid,
    input  logic [XLEN-1:0] i_req0_instr,
    output logic            o_req0_ready,
    input  logic            i_req1_valid,
    input  logic [XLEN-1:0] i_req1_instr,
    output logic            o_req1_ready,
    output logic            o_rsp_valid,
    output logic [XLEN-1:0] o_rsp_imm,
    output logic            o_rsp_id,
    input  logic            i_rsp_ready
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic            id_q, id_d;
    logic            rr_ptr_q, rr_ptr_d;

    logic            free;
    logic            can_grant;
    logic            gnt0, gnt1;
    logic            accept;
    logic [XLEN-1:0] mux_instr;
    logic [XLEN-1:0] gen_imm;

    // Readies are forced low during reset so nothing is consumed while the slot is being cleared.
    assign free      = !valid_q || i_rsp_ready;
    assign can_grant = free && !i_flush && !i_rst;
    assign gnt0      = can_grant && i_req0_valid && (!i_req1_valid || !rr_ptr_q);
    assign gnt1      = can_grant && i_req1_valid && (!i_req0_valid ||  rr_ptr_q);
    assign accept    = gnt0 || gnt1;
    assign mux_instr = gnt1 ? i_req1_instr : i_req0_instr;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (mux_instr),
        .imm_o   (gen_imm)
    );

    always_comb begin
        valid_d  = valid_q;
        imm_d    = imm_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            imm_d    = gen_imm;
            id_d     = gnt1;
            rr_ptr_d = !gnt1;
        end else if (i_rsp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q  <= 1'b0;
            imm_q    <= '0;
            id_q     <= 1'b0;
            rr_ptr_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            imm_q    <= imm_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign o_req0_ready = gnt0;
    assign o_req1_ready = gnt1;
    assign o_rsp_valid  = valid_q;
    assign o_rsp_imm    = imm_q;
    assign o_rsp_id     = id_q;
endmodule

// File: tb/tb_imm_share_arb.sv
// tb/tb_imm_share_arb.sv - directed vector bench for imm_share_arb
module tb_imm_share_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        v0, v1, r0, r1;
    logic [31:0] i0, i1;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_imm;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    imm_share_arb #(.XLEN(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_req0_valid (v0),
        .i_req0_instr (i0),
        .o_req0_ready (r0),
        .i_req1_valid (v1),
        .i_req1_instr (i1),
        .o_req1_ready (r1),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_imm    (rsp_imm),
        .o_rsp_id     (rsp_id),
        .i_rsp_ready  (rsp_ready)
    );

    typedef struct {
        logic        v0;
        logic [31:0] i0;
        logic        v1;
        logic [31:0] i1;
        logic        rr;
        logic        fl;
        logic        er0;
        logic        er1;
        logic        ev;
        logic [31:0] eimm;
        logic        eid;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] ADDI_M1 = 32'hFFF00093;
    localparam logic [31:0] LUI     = 32'h123450B7;
    localparam logic [31:0] SW8     = 32'h00112423;
    localparam logic [31:0] BNEG    = 32'hFE000EE3;
    localparam logic [31:0] JAL0    = 32'h0000006F;

    task automatic add(input logic a_v0, input logic [31:0] a_i0,
                       input logic a_v1, input logic [31:0] a_i1,
                       input logic a_rr, input logic a_fl,
                       input logic a_er0, input logic a_er1,
                       input logic a_ev, input logic [31:0] a_eimm, input logic a_eid);
        vec_t v;
        v.v0 = a_v0; v.i0 = a_i0; v.v1 = a_v1; v.i1 = a_i1;
        v.rr = a_rr; v.fl = a_fl; v.er0 = a_er0; v.er1 = a_er1;
        v.ev = a_ev; v.eimm = a_eimm; v.eid = a_eid;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        else
            passed++;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
        v0 = 1'b1; i0 = ADDI_M1; v1 = 1'b0; i1 = '0;

        // single port 0, then port 1 format stream
        add(1, ADDI_M1, 0, 0,    1, 0, 1, 0, 1, 32'hFFFFFFFF, 0);
        add(0, 0,       1, LUI,  1, 0, 0, 1, 1, 32'h12345000, 1);
        add(0, 0,       1, SW8,  1, 0, 0, 1, 1, 32'h00000008, 1);
        add(0, 0,       1, BNEG, 1, 0, 0, 1, 1, 32'hFFFFFFFC, 1);
        add(0, 0,       1, JAL0, 1, 0, 0, 1, 1, 32'h00000000, 1);
        add(0, 0,       0, 0,    1, 0, 0, 0, 0, 0,            0);
        // both valid: strict alternation starting at port 0
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) add(1, ADDI_M1, 1, LUI, 1, 0, 1, 0, 1, 32'hFFFFFFFF, 0);
            else            add(1, ADDI_M1, 1, LUI, 1, 0, 0, 1, 1, 32'h12345000, 1);
        end
        add(0, 0,       0, 0,    1, 0, 0, 0, 0, 0,            0);
        // backpressure
        add(1, ADDI_M1, 0, 0,    1, 0, 1, 0, 1, 32'hFFFFFFFF, 0);
        for (int k = 0; k < 3; k++)
            add(0, 0,   1, SW8,  0, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
        add(0, 0,       1, SW8,  1, 0, 0, 1, 1, 32'h00000008, 1);
        // flush with slot full: no grant, slot drops, pointer kept at 0
        add(1, ADDI_M1, 0, 0,    0, 1, 0, 0, 0, 0,            0);
        add(1, ADDI_M1, 1, SW8,  1, 0, 1, 0, 1, 32'hFFFFFFFF, 0);
        add(0, 0,       0, 0,    1, 0, 0, 0, 0, 0,            0);
        // flush with slot empty beats accept, pointer kept at 1
        add(1, ADDI_M1, 0, 0,    1, 1, 0, 0, 0, 0,            0);
        add(1, ADDI_M1, 1, SW8,  1, 0, 0, 1, 1, 32'h00000008, 1);
        add(0, 0,       0, 0,    1, 0, 0, 0, 0, 0,            0);

        // reset state
        #12;
        check("rst ready0", {31'b0, r0}, 32'd0);
        check("rst ready1", {31'b0, r1}, 32'd0);
        check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst rsp_imm", rsp_imm, 32'd0);
        check("rst rsp_id", {31'b0, rsp_id}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[k]) begin
            v0 = vecs[k].v0; i0 = vecs[k].i0; v1 = vecs[k].v1; i1 = vecs[k].i1;
            rsp_ready = vecs[k].rr; flush = vecs[k].fl;
            #1;
            check($sformatf("v%0d ready0", k), {31'b0, r0}, {31'b0, vecs[k].er0});
            check($sformatf("v%0d ready1", k), {31'b0, r1}, {31'b0, vecs[k].er1});
            @(posedge clk);
            #1;
            check($sformatf("v%0d rsp_valid", k), {31'b0, rsp_valid}, {31'b0, vecs[k].ev});
            if (vecs[k].ev) begin
                check($sformatf("v%0d rsp_imm", k), rsp_imm, vecs[k].eimm);
                check($sformatf("v%0d rsp_id", k), {31'b0, rsp_id}, {31'b0, vecs[k].eid});
            end
            @(negedge clk);
        end

        // async reset mid-cycle with a held result; pointer is 1 before reset
        v0 = 1'b1; i0 = ADDI_M1; v1 = 1'b0; rsp_ready = 1'b1; flush = 1'b0;
        @(posedge clk);
        #1;
        check("ar load valid", {31'b0, rsp_valid}, 32'd1);
        v0 = 1'b1; v1 = 1'b0; rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("ar valid drop", {31'b0, rsp_valid}, 32'd0);
        check("ar imm clear", rsp_imm, 32'd0);
        check("ar ready0 low", {31'b0, r0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        v0 = 1'b1; v1 = 1'b1; i1 = LUI; rsp_ready = 1'b1;
        #1;
        check("ar tie ready0", {31'b0, r0}, 32'd1);
        check("ar tie ready1", {31'b0, r1}, 32'd0);
        @(posedge clk);
        #1;
        check("ar tie rsp_id", {31'b0, rsp_id}, 32'd0);
        check("ar tie rsp_imm", rsp_imm, 32'hFFFFFFFF);
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
